// File: rtl/rv32im_bus_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared Wishbone port.
// Signal names follow the arbiter's point of view; "master" is the arbiter side.
interface rv32im_bus_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int XLEN        = 32
);
    logic [NUM_MASTERS-1:0]          req_i;
    logic [NUM_MASTERS-1:0]          grant_o;
    logic [NUM_MASTERS*(XLEN-2)-1:0] m_adr_i;
    logic [NUM_MASTERS*XLEN-1:0]     m_dat_i;
    logic [NUM_MASTERS*4-1:0]        m_sel_i;
    logic [NUM_MASTERS-1:0]          m_cyc_i;
    logic [NUM_MASTERS-1:0]          m_stb_i;
    logic [NUM_MASTERS-1:0]          m_we_i;
    logic [NUM_MASTERS-1:0]          m_ack_o;
    logic [NUM_MASTERS-1:0]          m_err_o;
    logic [XLEN-3:0]                 adr_o;
    logic [XLEN-1:0]                 dat_o;
    logic [3:0]                      sel_o;
    logic                            cyc_o;
    logic                            stb_o;
    logic                            we_o;
    logic                            ack_i;
    logic                            err_i;
    logic                            timeout_o;

    modport master (
        input  req_i, m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, ack_i, err_i,
        output grant_o, m_ack_o, m_err_o, adr_o, dat_o, sel_o, cyc_o, stb_o, we_o, timeout_o
    );

    modport slave (
        output req_i, m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, ack_i, err_i,
        input  grant_o, m_ack_o, m_err_o, adr_o, dat_o, sel_o, cyc_o, stb_o, we_o, timeout_o
    );
endinterface

// File: rtl/rv32im_bus_arbiter.sv
// Shares one Wishbone master port between NUM_MASTERS requesters with a stall watchdog.
// Define RV32IM_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed priority (index 0 highest).
module rv32im_bus_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_BITS       = 11
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    rv32im_bus_arbiter_if.master bus
);
    localparam int AW    = XLEN - 2;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, OWNED} state_e;

    state_e                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] win_oh;
    logic                   any_req;
    logic                   owner_req;
    logic                   wd_abort;

    logic [AW-1:0]          adr_mux;
    logic [XLEN-1:0]        dat_mux;
    logic [3:0]             sel_mux;
    logic                   cyc_mux;
    logic                   stb_mux;
    logic                   we_mux;

    assign any_req   = |bus.req_i;
    assign owner_req = |(bus.req_i & grant_q);

`ifdef RV32IM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] win_idx;
    int               cand;

    // Search starts just above the last owner and wraps, so every requester gets a turn.
    always_comb begin
        win_oh  = '0;
        win_idx = rr_q;
        cand    = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = (int'(rr_q) + k) % NUM_MASTERS;
            if ((win_oh == '0) && bus.req_i[IDX_W'(cand)]) begin
                win_oh[IDX_W'(cand)] = 1'b1;
                win_idx              = IDX_W'(cand);
            end
        end
    end
`else
    always_comb begin
        win_oh = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if ((win_oh == '0) && bus.req_i[k]) begin
                win_oh[k] = 1'b1;
            end
        end
    end
`endif

    // Tenure FSM: a release always passes through IDLE, giving one dead cycle between owners.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
            rr_q    <= IDX_W'(NUM_MASTERS - 1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= OWNED;
                        grant_q <= win_oh;
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
                        rr_q    <= win_idx;
`endif
                    end
                end
                OWNED: begin
                    if (!owner_req) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Grant is one-hot or zero, so a priority-free select gives all-zero outputs when idle.
    always_comb begin
        adr_mux = '0;
        dat_mux = '0;
        sel_mux = '0;
        cyc_mux = 1'b0;
        stb_mux = 1'b0;
        we_mux  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                adr_mux = bus.m_adr_i[k*AW +: AW];
                dat_mux = bus.m_dat_i[k*XLEN +: XLEN];
                sel_mux = bus.m_sel_i[k*4 +: 4];
                cyc_mux = bus.m_cyc_i[k];
                stb_mux = bus.m_stb_i[k];
                we_mux  = bus.m_we_i[k];
            end
        end
    end

    assign bus.adr_o = adr_mux;
    assign bus.dat_o = dat_mux;
    assign bus.sel_o = sel_mux;
    assign bus.cyc_o = cyc_mux;
    assign bus.stb_o = stb_mux;
    assign bus.we_o  = we_mux & stb_mux;

    assign bus.m_ack_o   = {NUM_MASTERS{bus.ack_i}} & grant_q;
    assign bus.m_err_o   = {NUM_MASTERS{bus.err_i | wd_abort}} & grant_q;
    assign bus.grant_o   = grant_q;
    assign bus.timeout_o = wd_abort;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            logic [CNT_BITS-1:0] cnt_q;
            logic [CNT_BITS-1:0] cnt_d;
            logic                stall;

            assign stall    = stb_mux & ~bus.ack_i & ~bus.err_i;
            assign wd_abort = stall && (cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1));

            // Count holds while the owner idles its strobe; any response or an abort restarts it.
            always_comb begin
                cnt_d = cnt_q;
                if ((state_q == IDLE) || bus.ack_i || bus.err_i || wd_abort) begin
                    cnt_d = '0;
                end else if (stall) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_no_wd
            assign wd_abort = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// Randomised bench for rv32im_bus_arbiter with an integer-level reference model and directed checks.
module tb_rv32im_bus_arbiter;
    localparam int NM   = 3;
    localparam int XL   = 32;
    localparam int AW   = XL - 2;
    localparam int TO   = 4;
    localparam int CB   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rv32im_bus_arbiter_if #(.NUM_MASTERS(NM), .XLEN(XL)) bus ();

    rv32im_bus_arbiter #(
        .NUM_MASTERS(NM), .XLEN(XL), .TIMEOUT_CYCLES(TO), .CNT_BITS(CB)
    ) dut (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: current owner (-1 when idle), rotation pointer, stalled-cycle count.
    int m_owner = -1;
    int m_rr    = NM - 1;
    int m_cnt   = 0;

    function automatic int pick(input logic [NM-1:0] r);
        int w = -1;
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NM; k++)
            if (w < 0 && r[(m_rr + k) % NM]) w = (m_rr + k) % NM;
`else
        for (int k = 0; k < NM; k++)
            if (w < 0 && r[k]) w = k;
`endif
        return w;
    endfunction

    function automatic bit abort_now();
        if (TO == 0 || m_owner < 0) return 1'b0;
        return bus.m_stb_i[m_owner] && !bus.ack_i && !bus.err_i && (m_cnt == TO - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_rr    <= NM - 1;
            m_cnt   <= 0;
        end else if (m_owner < 0) begin
            m_cnt <= 0;
            if (|bus.req_i) begin
                m_owner <= pick(bus.req_i);
                m_rr    <= pick(bus.req_i);
            end
        end else begin
            if (bus.ack_i || bus.err_i || abort_now()) m_cnt <= 0;
            else if (bus.m_stb_i[m_owner]) m_cnt <= m_cnt + 1;
            if (!bus.req_i[m_owner]) m_owner <= -1;
        end
    end

    logic [31:0] e_grant, e_adr, e_dat, e_sel, e_cyc, e_stb, e_we, e_ack, e_err, e_to;

    always @(negedge clk) begin
        e_grant = 0; e_adr = 0; e_dat = 0; e_sel = 0; e_cyc = 0;
        e_stb = 0; e_we = 0; e_ack = 0; e_err = 0; e_to = 0;
        if (m_owner >= 0) begin
            e_grant = 32'd1 << m_owner;
            e_adr   = 32'(bus.m_adr_i[m_owner*AW +: AW]);
            e_dat   = bus.m_dat_i[m_owner*XL +: XL];
            e_sel   = 32'(bus.m_sel_i[m_owner*4 +: 4]);
            e_cyc   = 32'(bus.m_cyc_i[m_owner]);
            e_stb   = 32'(bus.m_stb_i[m_owner]);
            e_we    = 32'(bus.m_we_i[m_owner] & bus.m_stb_i[m_owner]);
            e_ack   = bus.ack_i ? e_grant : 0;
            e_to    = 32'(abort_now());
            e_err   = (bus.err_i || abort_now()) ? e_grant : 0;
        end
        chk("grant",   32'(bus.grant_o),   e_grant);
        chk("adr",     32'(bus.adr_o),     e_adr);
        chk("dat",     bus.dat_o,          e_dat);
        chk("sel",     32'(bus.sel_o),     e_sel);
        chk("cyc",     32'(bus.cyc_o),     e_cyc);
        chk("stb",     32'(bus.stb_o),     e_stb);
        chk("we",      32'(bus.we_o),      e_we);
        chk("m_ack",   32'(bus.m_ack_o),   e_ack);
        chk("m_err",   32'(bus.m_err_o),   e_err);
        chk("timeout", 32'(bus.timeout_o), e_to);
    end

    task automatic cyc_();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_i   = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.ack_i   = 1'b0;
        bus.err_i   = 1'b0;
    endtask

    task automatic go_idle();
        clear_inputs();
        cyc_();
        cyc_();
    endtask

    initial begin
        logic [NM-1:0] rq;
        clear_inputs();
        #3;
        chk("reset grant", 32'(bus.grant_o), 0);
        chk("reset stb", 32'(bus.stb_o), 0);
        chk("reset timeout", 32'(bus.timeout_o), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        cyc_();

`ifdef RV32IM_ARB_ROUND_ROBIN_EN
        bus.req_i = 3'b111;
        cyc_();
        for (int j = 0; j < 4; j++) begin
            #1 chk("rr order", 32'(bus.grant_o), 32'd1 << (j % NM));
            bus.m_stb_i = 3'b111;
            bus.ack_i   = 1'b1;
            rq = 3'b111;
            rq[j % NM] = 1'b0;
            bus.req_i = rq;
            cyc_();
            bus.ack_i = 1'b0;
            #1 chk("rr gap", 32'(bus.grant_o), 0);
            bus.req_i = 3'b111;
            cyc_();
        end
`else
        bus.req_i = 3'b111;
        cyc_();
        #1 chk("fp first", 32'(bus.grant_o), 1);
        bus.req_i = 3'b110;
        cyc_();
        #1 chk("fp gap1", 32'(bus.grant_o), 0);
        cyc_();
        #1 chk("fp second", 32'(bus.grant_o), 2);
        bus.req_i = 3'b100;
        cyc_();
        #1 chk("fp gap2", 32'(bus.grant_o), 0);
        cyc_();
        #1 chk("fp third", 32'(bus.grant_o), 4);
`endif
        go_idle();

        // Isolation and bus mux for owner 2.
        bus.req_i = 3'b100;
        bus.m_adr_i[2*AW +: AW] = 30'h1234567;
        bus.m_we_i[2] = 1'b1;
        cyc_();
        #1 chk("iso grant", 32'(bus.grant_o), 4);
        chk("iso adr", 32'(bus.adr_o), 32'h1234567);
        chk("we gated", 32'(bus.we_o), 0);
        bus.m_stb_i[2] = 1'b1;
        bus.ack_i = 1'b1;
        #1 chk("iso ack", 32'(bus.m_ack_o), 4);
        chk("we pass", 32'(bus.we_o), 1);
        go_idle();
        bus.err_i = 1'b1;
        #1 chk("idle err", 32'(bus.m_err_o), 0);
        chk("idle adr", 32'(bus.adr_o), 0);
        bus.err_i = 1'b0;
        cyc_();

        // Watchdog: abort on every 4th stalled cycle.
        bus.req_i = 3'b001;
        bus.m_stb_i[0] = 1'b1;
        bus.m_cyc_i[0] = 1'b1;
        cyc_();
        for (int i = 1; i <= 8; i++) begin
            #1 chk("wd timeout", 32'(bus.timeout_o), (i % 4 == 0) ? 1 : 0);
            chk("wd err", 32'(bus.m_err_o), (i % 4 == 0) ? 1 : 0);
            cyc_();
        end
        for (int i = 1; i <= 6; i++) begin
            bus.ack_i = (i == 3);
            #1 chk("wd acked", 32'(bus.timeout_o), 0);
            cyc_();
        end
        go_idle();

        // Ack and release in the same cycle, with another request pending.
        bus.req_i = 3'b001;
        cyc_();
        #1 chk("rel grant", 32'(bus.grant_o), 1);
        bus.m_stb_i[0] = 1'b1;
        bus.req_i = 3'b010;
        bus.ack_i = 1'b1;
        #1 chk("rel ack", 32'(bus.m_ack_o), 1);
        cyc_();
        bus.ack_i = 1'b0;
        #1 chk("rel gap", 32'(bus.grant_o), 0);
        cyc_();
        #1 chk("rel next", 32'(bus.grant_o), 2);
        go_idle();

        // Asynchronous reset in the middle of a tenure.
        bus.req_i = 3'b010;
        bus.m_stb_i[1] = 1'b1;
        bus.m_cyc_i[1] = 1'b1;
        cyc_();
        #1 chk("pre-rst grant", 32'(bus.grant_o), 2);
        rst_n = 1'b0;
        #1 chk("rst grant", 32'(bus.grant_o), 0);
        chk("rst stb", 32'(bus.stb_o), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc_();
        #1 chk("post-rst grant", 32'(bus.grant_o), 2);

        // Random traffic against the model.
        rq = '0;
        for (int n = 0; n < 3000; n++) begin
            cyc_();
            for (int k = 0; k < NM; k++) begin
                if ($urandom_range(0, 9) == 0) rq[k] = ~rq[k];
                bus.m_adr_i[k*AW +: AW] = AW'($urandom());
                bus.m_dat_i[k*XL +: XL] = $urandom();
                bus.m_sel_i[k*4 +: 4]   = 4'($urandom());
                bus.m_stb_i[k] = ($urandom_range(0, 3) != 0);
                bus.m_cyc_i[k] = bus.m_stb_i[k] | 1'($urandom());
                bus.m_we_i[k]  = 1'($urandom());
            end
            bus.req_i = rq;
            bus.ack_i = ($urandom_range(0, 9) < 2);
            bus.err_i = ($urandom_range(0, 19) == 0);
            if (n % 700 == 350) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
